// File: rtl/fwd_scoreboard.sv
// Decode-stage operand forwarding and load-use hazard unit.
// Tracks in-flight destination registers in a shift-register scoreboard
// (entry 0 = E stage, entry STAGES-1 = W stage) and, for each decode read port,
// forwards the youngest in-flight producer or falls back to the register file.
module fwd_scoreboard #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned AW         = 5,
    parameter int unsigned STAGES     = 3,
    parameter int unsigned NRD        = 2,
    parameter int unsigned LOAD_READY = 1,
    parameter int unsigned SW         = $clog2(STAGES + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    IssueValid,
    input  logic [AW-1:0]           IssueDst,
    input  logic                    IssueRegWrite,
    input  logic                    IssueIsLoad,
    input  logic                    Hold,
    input  logic                    Flush,
    input  logic [NRD*AW-1:0]       SrcAddr,
    input  logic [NRD*WIDTH-1:0]    RD,
    input  logic [STAGES*WIDTH-1:0] StageData,
    output logic [NRD*WIDTH-1:0]    Operand,
    output logic [NRD*SW-1:0]       FwdSel,
    output logic                    Stall,
    output logic [15:0]             StallCount
);

    // Scoreboard entries, one per in-flight stage.
    logic [STAGES-1:0]         ent_v_q,   ent_v_d;
    logic [STAGES-1:0][AW-1:0] ent_dst_q, ent_dst_d;
    logic [STAGES-1:0]         ent_ld_q,  ent_ld_d;
    logic [15:0]               cnt_q,     cnt_d;

    logic [STAGES-1:0]         ent_wr;
    logic [STAGES-1:0]         ent_rdy;
    logic [NRD-1:0]            port_hit;
    logic [NRD-1:0]            port_rdy;
    logic                      issue_wr;

    // Per-entry qualifiers: writes a real register / result available on StageData.
    always_comb begin
        ent_wr  = '0;
        ent_rdy = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            // dst == 0 never matches, so r0 writers are invisible to forwarding.
            ent_wr[i]  = ent_v_q[i] && (ent_dst_q[i] != '0);
            ent_rdy[i] = !ent_ld_q[i] || (i >= int'(LOAD_READY));
        end
    end

    // Forwarding mux: scan oldest to youngest so the youngest match overwrites.
    // The W entry is included because the register file is read-first and
    // still holds the stale value during write-back.
    always_comb begin
        Operand  = RD;
        FwdSel   = '0;
        port_hit = '0;
        port_rdy = '1;
        for (int p = 0; p < int'(NRD); p++) begin
            for (int i = int'(STAGES) - 1; i >= 0; i--) begin
                if (ent_wr[i] && (ent_dst_q[i] == SrcAddr[p*AW +: AW])) begin
                    port_hit[p]               = 1'b1;
                    port_rdy[p]               = ent_rdy[i];
                    FwdSel[p*SW +: SW]        = SW'(i + 1);
                    Operand[p*WIDTH +: WIDTH] = StageData[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Load-use hazard: only the winning (youngest) match decides readiness,
    // and a flushed decode instruction never stalls.
    always_comb begin
        Stall = IssueValid && !Flush && |(port_hit & ~port_rdy);
    end

    // Next scoreboard state: shift toward W, insert the decode instruction or a bubble.
    always_comb begin
        issue_wr  = IssueValid && IssueRegWrite && !Flush && !Stall;
        ent_v_d   = ent_v_q;
        ent_dst_d = ent_dst_q;
        ent_ld_d  = ent_ld_q;
        for (int i = 1; i < int'(STAGES); i++) begin
            ent_v_d[i]   = ent_v_q[i-1];
            ent_dst_d[i] = ent_dst_q[i-1];
            ent_ld_d[i]  = ent_ld_q[i-1];
        end
        ent_v_d[0]   = issue_wr;
        ent_dst_d[0] = IssueDst;
        ent_ld_d[0]  = IssueIsLoad;
    end

    // Next stall count, saturating at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (Stall && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // State registers; Hold freezes everything, including the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_v_q   <= '0;
            ent_dst_q <= '0;
            ent_ld_q  <= '0;
            cnt_q     <= '0;
        end else if (!Hold) begin
            ent_v_q   <= ent_v_d;
            ent_dst_q <= ent_dst_d;
            ent_ld_q  <= ent_ld_d;
            cnt_q     <= cnt_d;
        end
    end

    // Counter output.
    always_comb begin
        StallCount = cnt_q;
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed self-checking bench for fwd_scoreboard.
// u_dut uses the default configuration; u_sat is a deep instance whose loads
// never become ready in the scoreboard, used to drive the stall counter to saturation.
module tb_fwd_scoreboard;

    localparam logic [31:0] SD0 = 32'h0000_1234;
    localparam logic [31:0] SD1 = 32'h5555_1111;
    localparam logic [31:0] SD2 = 32'h6666_2222;
    localparam logic [31:0] RD0 = 32'hAAAA_0000;
    localparam logic [31:0] RD1 = 32'hBBBB_0001;

    logic        clk;
    logic        rst_n;
    logic        iss_v;
    logic [4:0]  iss_dst;
    logic        iss_rw;
    logic        iss_ld;
    logic        hold;
    logic        flush;
    logic [9:0]  src;
    logic [63:0] rd;
    logic [95:0] sd;
    logic [63:0] operand;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic [15:0] stall_cnt;

    logic          s_v;
    logic [4:0]    s_dst;
    logic          s_rw;
    logic          s_ld;
    logic [4:0]    s_src;
    logic [31:0]   s_rd;
    logic [1023:0] s_sd;
    logic [31:0]   s_operand;
    logic [5:0]    s_fwd;
    logic          s_stall;
    logic [15:0]   s_cnt;

    int checks = 0;
    int errors = 0;

    fwd_scoreboard u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .IssueValid   (iss_v),
        .IssueDst     (iss_dst),
        .IssueRegWrite(iss_rw),
        .IssueIsLoad  (iss_ld),
        .Hold         (hold),
        .Flush        (flush),
        .SrcAddr      (src),
        .RD           (rd),
        .StageData    (sd),
        .Operand      (operand),
        .FwdSel       (fwd_sel),
        .Stall        (stall),
        .StallCount   (stall_cnt)
    );

    fwd_scoreboard #(
        .STAGES    (32),
        .LOAD_READY(32),
        .NRD       (1)
    ) u_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .IssueValid   (s_v),
        .IssueDst     (s_dst),
        .IssueRegWrite(s_rw),
        .IssueIsLoad  (s_ld),
        .Hold         (1'b0),
        .Flush        (1'b0),
        .SrcAddr      (s_src),
        .RD           (s_rd),
        .StageData    (s_sd),
        .Operand      (s_operand),
        .FwdSel       (s_fwd),
        .Stall        (s_stall),
        .StallCount   (s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [4:0] dst, input logic rw, input logic ld);
        iss_v   = v;
        iss_dst = dst;
        iss_rw  = rw;
        iss_ld  = ld;
    endtask

    initial begin
        rst_n = 1'b1;
        rd    = {RD1, RD0};
        sd    = {SD2, SD1, SD0};
        hold  = 1'b0;
        flush = 1'b0;
        s_v   = 1'b0;
        s_dst = 5'd0;
        s_rw  = 1'b0;
        s_ld  = 1'b0;
        s_src = 5'd0;
        s_rd  = 32'hCAFE_0000;
        s_sd  = '0;
        #1;
        // Reset with arbitrary, hazard-looking inputs.
        rst_n = 1'b0;
        issue(1'b1, 5'd5, 1'b1, 1'b1);
        src = {5'd5, 5'd5};
        #2;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_fwdsel", 32'(fwd_sel), 32'd0);
        chk("rst_op0", operand[31:0], RD0);
        chk("rst_op1", operand[63:32], RD1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        issue(1'b0, 5'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();

        // Released, nothing in flight: r5 comes from the register file.
        src = {5'd0, 5'd5};
        #1;
        chk("post_rst_sel0", 32'(fwd_sel[1:0]), 32'd0);
        chk("post_rst_op0", operand[31:0], RD0);

        // ALU producer r5.
        issue(1'b1, 5'd5, 1'b1, 1'b0);
        src = {5'd0, 5'd0};
        #1;
        chk("alu_issue_stall", 32'(stall), 32'd0);
        tick();
        issue(1'b1, 5'd0, 1'b0, 1'b0);
        src = {5'd0, 5'd5};
        #1;
        chk("alu_e_sel", 32'(fwd_sel[1:0]), 32'd1);
        chk("alu_e_op", operand[31:0], SD0);
        chk("alu_e_stall", 32'(stall), 32'd0);
        tick();
        #1;
        chk("alu_m_sel", 32'(fwd_sel[1:0]), 32'd2);
        chk("alu_m_op", operand[31:0], SD1);
        tick();
        #1;
        chk("alu_w_sel", 32'(fwd_sel[1:0]), 32'd3);
        chk("alu_w_op", operand[31:0], SD2);
        tick();
        #1;
        chk("alu_retired_sel", 32'(fwd_sel[1:0]), 32'd0);
        chk("alu_retired_op", operand[31:0], RD0);

        // Load-use: lw r7 then a reader of r7 on port 1.
        issue(1'b1, 5'd7, 1'b1, 1'b1);
        src = {5'd0, 5'd0};
        tick();
        issue(1'b1, 5'd8, 1'b1, 1'b0);
        src = {5'd7, 5'd0};
        #1;
        chk("lu_stall", 32'(stall), 32'd1);
        chk("lu_sel1", 32'(fwd_sel[3:2]), 32'd1);
        chk("lu_cnt_before", 32'(stall_cnt), 32'd0);
        tick();
        // Bubble went into e[0]; the load now sits in e[1] and is ready.
        #1;
        chk("lu_stall_released", 32'(stall), 32'd0);
        chk("lu_cnt", 32'(stall_cnt), 32'd1);
        chk("lu_sel1_after", 32'(fwd_sel[3:2]), 32'd2);
        chk("lu_op1_after", operand[63:32], SD1);
        tick();

        // Priority: r3 in e[1] alone, then in e[0] and e[2].
        issue(1'b1, 5'd3, 1'b1, 1'b0);
        src = {5'd0, 5'd0};
        tick();
        issue(1'b1, 5'd9, 1'b1, 1'b0);
        tick();
        issue(1'b1, 5'd3, 1'b1, 1'b0);
        src = {5'd0, 5'd3};
        #1;
        chk("prio_single_sel", 32'(fwd_sel[1:0]), 32'd2);
        tick();
        #1;
        chk("prio_young_sel", 32'(fwd_sel[1:0]), 32'd1);
        chk("prio_young_op", operand[31:0], SD0);

        // r0 as destination is never forwarded.
        issue(1'b1, 5'd0, 1'b1, 1'b0);
        tick();
        src = {5'd0, 5'd3};
        issue(1'b1, 5'd3, 1'b1, 1'b1);
        #1;
        chk("r0_sel1", 32'(fwd_sel[3:2]), 32'd0);
        chk("r0_op1", operand[63:32], RD1);
        chk("r0_stall", 32'(stall), 32'd0);
        chk("r0_sel0", 32'(fwd_sel[1:0]), 32'd2);
        tick();

        // Unready load r3 in e[0] shadows the ready ALU r3 in e[2]; freeze with Hold.
        issue(1'b1, 5'd3, 1'b1, 1'b0);
        hold = 1'b1;
        #1;
        chk("shadow_stall", 32'(stall), 32'd1);
        chk("shadow_sel", 32'(fwd_sel[1:0]), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_stall", 32'(stall), 32'd1);
            chk("hold_sel", 32'(fwd_sel[1:0]), 32'd1);
            chk("hold_cnt", 32'(stall_cnt), 32'd1);
        end

        // Flush with the hazard still present: no stall, bubble into e[0].
        hold  = 1'b0;
        flush = 1'b1;
        #1;
        chk("flush_stall", 32'(stall), 32'd0);
        tick();
        flush = 1'b0;
        issue(1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("flush_bubble_sel", 32'(fwd_sel[1:0]), 32'd2);
        chk("flush_bubble_op", operand[31:0], SD1);
        chk("flush_cnt", 32'(stall_cnt), 32'd1);

        // Fill with r4 writers, youngest a load, then reset between edges.
        issue(1'b1, 5'd4, 1'b1, 1'b0);
        src = {5'd0, 5'd4};
        tick();
        tick();
        issue(1'b1, 5'd4, 1'b1, 1'b1);
        tick();
        #1;
        chk("full_stall", 32'(stall), 32'd1);
        chk("full_sel", 32'(fwd_sel[1:0]), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_sel", 32'(fwd_sel[1:0]), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_op", operand[31:0], RD0);
        chk("midrst_cnt", 32'(stall_cnt), 32'd0);
        issue(1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Saturation: a load that reads its own destination re-stalls forever;
        // each 33-cycle group is one issue cycle followed by 32 stall cycles.
        s_v   = 1'b1;
        s_dst = 5'd7;
        s_rw  = 1'b1;
        s_ld  = 1'b1;
        s_src = 5'd7;
        #1;
        chk("sat_first_stall", 32'(s_stall), 32'd0);
        tick();
        chk("sat_stall", 32'(s_stall), 32'd1);
        chk("sat_sel", 32'(s_fwd), 32'd1);
        repeat (32) tick();
        chk("sat_group_cnt", 32'(s_cnt), 32'd32);
        chk("sat_group_stall", 32'(s_stall), 32'd0);
        repeat (67551 - 33) tick();
        chk("sat_pre_cnt", 32'(s_cnt), 32'd65504);
        repeat (33) tick();
        chk("sat_cnt", 32'(s_cnt), 32'h0000_FFFF);
        repeat (7) tick();
        chk("sat_hold_cnt", 32'(s_cnt), 32'h0000_FFFF);
        chk("sat_still_stall", 32'(s_stall), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
